// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and FSM state codes, also used by the transmitter.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: tick and serial line in, received byte and status pulses out.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = uart_pkg::UART_DATA_BITS
) ();

    logic                 baud_tick;
    logic                 rx_in;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        output baud_tick, rx_in,
        input  rx_data, rx_valid, rx_busy, frame_err, parity_err
    );

    modport slave (
        input  baud_tick, rx_in,
        output rx_data, rx_valid, rx_busy, frame_err, parity_err
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (start, LSB-first data, stop), centre-sampled on baud_tick.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
    input logic      clk,
    input logic      rst_n,
    uart_rx_if.slave bus
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 hold_q, hold_d;
    logic                 par_bad;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rx_in),
        .q     (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic perr_q, perr_d;
    assign par_bad        = ^{shift_q, par_q};
    assign bus.parity_err = perr_q;
`else
    assign par_bad        = 1'b0;
    assign bus.parity_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        // A break (line still low after a framing error) must end before a new start counts.
        hold_d  = hold_q & ~rx_s;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (!rx_s && !hold_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bus.baud_tick) begin
                    tick_d = tick_q + 1'b1;
                    if (tick_q == HALF_LAST) begin
                        tick_d  = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bus.baud_tick) begin
                    tick_d = tick_q + 1'b1;
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bus.baud_tick) begin
                    tick_d = tick_q + 1'b1;
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        par_d   = rx_s;
                        state_d = ST_STOP;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (bus.baud_tick) begin
                    tick_d = tick_q + 1'b1;
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_bad;
`endif
                        if (!rx_s) begin
                            ferr_d = 1'b1;
                            hold_d = 1'b1;
                        end else if (!par_bad) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            hold_q  <= hold_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end
`endif

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a frame-level reference model.
// Build with UART_RX_PARITY_EN defined to also exercise the parity frame format.
module tb_uart_rx;

    localparam int unsigned OS = 16;
    localparam int unsigned DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick  = 1'b0;
    int unsigned div   = 0;

    uart_rx_if #(.DATA_BITS(DB)) bus ();
    assign bus.baud_tick = tick;

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One baud_tick every third clock.
    always @(posedge clk) begin
        tick <= (div == 2);
        div  <= (div == 2) ? 0 : div + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Observed pulses, sampled on the falling edge.
    int         n_valid = 0, n_ferr = 0, n_perr = 0, n_wide = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            n_valid++;
            got_q.push_back(bus.rx_data);
        end
        if (bus.frame_err) n_ferr++;
        if (bus.parity_err) n_perr++;
        if (bus.rx_valid && valid_prev) n_wide++;
        valid_prev = bus.rx_valid;
    end

    // Reference model state.
    int         e_valid = 0, e_ferr = 0, e_perr = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] exp_q[$];
    logic       busy_mid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(negedge clk);
            if (tick) c++;
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.rx_in = b;
        wait_ticks(OS);
    endtask

    // Leaves the line at the stop level; callers restore idle when needed.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) begin
            bus.rx_in = data[i];
            wait_ticks(OS / 2);
            if (i == 4) busy_mid = bus.rx_busy;
            wait_ticks(OS / 2);
        end
        if (PARITY) drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic model_frame(input logic [7:0] data, input logic stop, input logic par);
        logic bad;
        bad = PARITY && ((^data) != par);
        if (bad) e_perr++;
        if (!stop) begin
            e_ferr++;
        end else if (!bad) begin
            e_valid++;
            exp_q.push_back(data);
            last_good = data;
        end
    endtask

    task automatic expect_state(input string tag);
        check({tag, " rx_valid count"}, n_valid, e_valid);
        check({tag, " frame_err count"}, n_ferr, e_ferr);
        check({tag, " parity_err count"}, n_perr, e_perr);
        check({tag, " rx_data"}, {24'h0, bus.rx_data}, {24'h0, last_good});
        check({tag, " rx_busy idle"}, {31'h0, bus.rx_busy}, 0);
        check({tag, " received count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, " data order"}, {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       stop;
        logic       par;
        int         gap;

        bus.rx_in = 1'b1;
        repeat (4) @(negedge clk);
        check("reset rx_data", {24'h0, bus.rx_data}, 0);
        check("reset rx_valid", {31'h0, bus.rx_valid}, 0);
        check("reset rx_busy", {31'h0, bus.rx_busy}, 0);
        check("reset frame_err", {31'h0, bus.frame_err}, 0);
        check("reset parity_err", {31'h0, bus.parity_err}, 0);
        rst_n = 1'b1;
        wait_ticks(4);

        send_frame(8'hA5, 1'b1, ^8'hA5);
        model_frame(8'hA5, 1'b1, ^8'hA5);
        check("a5 busy mid-frame", {31'h0, busy_mid}, 1);
        expect_state("a5");

        // Short low glitch on an idle line.
        bus.rx_in = 1'b0;
        wait_ticks(3);
        check("glitch busy", {31'h0, bus.rx_busy}, 1);
        wait_ticks(1);
        bus.rx_in = 1'b1;
        wait_ticks(OS);
        expect_state("glitch");

        send_frame(8'h3C, 1'b0, ^8'h3C);
        bus.rx_in = 1'b1;
        model_frame(8'h3C, 1'b0, ^8'h3C);
        wait_ticks(OS);
        expect_state("stop low");

        send_frame(8'h55, 1'b1, ^8'h55);
        send_frame(8'hAA, 1'b1, ^8'hAA);
        model_frame(8'h55, 1'b1, ^8'h55);
        model_frame(8'hAA, 1'b1, ^8'hAA);
        expect_state("back-to-back");

        // Reset in the middle of data bit 4 of 0xFF.
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        wait_ticks(OS / 2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-frame reset busy", {31'h0, bus.rx_busy}, 0);
        rst_n = 1'b1;
        last_good = 8'h00;
        wait_ticks(OS * 5);
        expect_state("after reset");
        send_frame(8'h12, 1'b1, ^8'h12);
        model_frame(8'h12, 1'b1, ^8'h12);
        expect_state("post-reset 12");

        // Break: line stays low after a framing error.
        send_frame(8'hC3, 1'b0, ^8'hC3);
        model_frame(8'hC3, 1'b0, ^8'hC3);
        wait_ticks(OS * 3);
        expect_state("break held");
        bus.rx_in = 1'b1;
        wait_ticks(OS);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        model_frame(8'h5A, 1'b1, ^8'h5A);
        expect_state("after break");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        model_frame(8'h07, 1'b1, 1'b0);
        expect_state("parity wrong");
        send_frame(8'h07, 1'b1, 1'b1);
        model_frame(8'h07, 1'b1, 1'b1);
        expect_state("parity right");
`endif

        for (int f = 0; f < 24; f++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            par  = (^d) ^ ($urandom_range(0, 4) == 0);
            send_frame(d, stop, par);
            model_frame(d, stop, par);
            gap = $urandom_range(0, 2);
            if (!stop && gap == 0) gap = 1;
            bus.rx_in = 1'b1;
            if (gap > 0) wait_ticks(OS * gap);
            check("random rx_data", {24'h0, bus.rx_data}, {24'h0, last_good});
        end
        wait_ticks(OS);
        expect_state("random");
        check("rx_valid one clk wide", n_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
